// File: rtl/gp_writeback_scheduler.sv
// Writeback scheduler for the GPR file: owns the single write port, arbitrates
// ALU vs load writebacks, and tracks pending writes for decode hazard detection.
module gp_writeback_scheduler #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int IW          = $clog2(NREG),
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [IW-1:0]   issue_rd,
    input  logic [IW-1:0]   src1_idx,
    input  logic [IW-1:0]   src2_idx,
    output logic            issue_ready,
    output logic            hazard,
    input  logic            alu_valid,
    input  logic [IW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [IW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            rf_write_enable,
    output logic [IW-1:0]   rf_write_idx,
    output logic [XLEN-1:0] rf_write_data,
    output logic [NREG-1:0] busy_out
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            wen_q, wen_d;
    logic [IW-1:0]   widx_q, widx_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [NREG-1:0] clear_mask, set_mask, ebusy;
    logic            alu_nz, mem_nz, alu_win, mem_win;

    always_comb begin
        clear_mask = '0;
        if (wen_q) clear_mask = NREG'(1) << widx_q;
        // Same-cycle writes are forwarded by the register file.
        ebusy  = busy_q & ~clear_mask;
        hazard = issue_valid && (ebusy[src1_idx] || ebusy[src2_idx] || ebusy[issue_rd]);
        issue_ready = !hazard;
    end

    always_comb begin
        alu_nz  = alu_valid && (alu_rd != '0);
        mem_nz  = mem_valid && (mem_rd != '0);
        alu_win = alu_nz && (!mem_nz || (starve_q >= SW'(STARVE_LIMIT)));
        mem_win = mem_nz && !alu_win;
        // x0 requests are absorbed without touching the write port.
        alu_ready = alu_valid && ((alu_rd == '0) || alu_win);
        mem_ready = mem_valid && ((mem_rd == '0) || mem_win);
    end

    always_comb begin
        starve_d = starve_q;
        if (!alu_valid || alu_ready)
            starve_d = '0;
        else if (alu_nz && (starve_q < SW'(STARVE_LIMIT)))
            starve_d = starve_q + SW'(1);
    end

    always_comb begin
        wen_d   = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        if (alu_win) begin
            wen_d   = 1'b1;
            widx_d  = alu_rd;
            wdata_d = alu_data;
        end else if (mem_win) begin
            wen_d   = 1'b1;
            widx_d  = mem_rd;
            wdata_d = mem_data;
        end
    end

    always_comb begin
        set_mask = '0;
        if (issue_valid && issue_ready) set_mask = NREG'(1) << issue_rd;
        // Set is OR'd after the clear so a colliding issue keeps the bit.
        busy_d    = (busy_q & ~clear_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            starve_q <= '0;
            wen_q    <= 1'b0;
            widx_q   <= '0;
            wdata_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
        end
    end

    assign rf_write_enable = wen_q;
    assign rf_write_idx    = widx_q;
    assign rf_write_data   = wdata_q;
    assign busy_out        = busy_q;

endmodule
